// File: rtl/usb_sync_fifo.sv
// usb_sync_fifo: single-clock byte FIFO with early full/empty flags between ezusb_if and the core
// Ports:
//   clk, rst         clock; asynchronous active-high reset
//   wr, wdata        write strobe and data
//   rd, rdata        read strobe; registered data one cycle after an accepted read
//   full, fullm1     count == DEPTH, count >= DEPTH-1
//   empty, emptyp1   count == 0, count <= 1
//   level            occupancy 0..DEPTH
//   ovf, udf         sticky write-while-full / read-while-empty errors
//   clr_err          synchronous clear of ovf and udf (a coincident error wins)
module usb_sync_fifo #(
    parameter int DW = 8,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [DW-1:0] wdata,
    input  logic          rd,
    output logic [DW-1:0] rdata,
    output logic          full,
    output logic          fullm1,
    output logic          empty,
    output logic          emptyp1,
    output logic [AW:0]   level,
    output logic          ovf,
    output logic          udf,
    input  logic          clr_err
);
    localparam int N = 1 << AW;
    localparam logic [AW:0] DEPTH = (AW+1)'(N);
    logic [DW-1:0] mem [0:N-1];
    logic [AW-1:0] wptr, rptr;
    logic [AW:0]   count, count_n;
    logic          wr_ok, rd_ok;
    assign wr_ok = wr & (~full | rd);
    assign rd_ok = rd & ~empty;
    assign level = count;
    always_comb count_n = (wr_ok && !rd_ok) ? count + 1'b1 : (rd_ok && !wr_ok) ? count - 1'b1 : count;
    // Storage is deliberately not reset; read of the old entry when wptr == rptr falls out of NBA ordering.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr] <= wdata;
    end
    // Flags are decoded from the next count and registered so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            count   <= '0;
            rdata   <= '0;
            full    <= 1'b0;
            fullm1  <= 1'b0;
            empty   <= 1'b1;
            emptyp1 <= 1'b1;
            ovf     <= 1'b0;
            udf     <= 1'b0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) begin
                rptr  <= rptr + 1'b1;
                rdata <= mem[rptr];
            end
            count   <= count_n;
            full    <= count_n == DEPTH;
            fullm1  <= count_n >= DEPTH - 1'b1;
            empty   <= count_n == '0;
            emptyp1 <= count_n <= (AW+1)'(1);
            ovf     <= (wr & full & ~rd) | (ovf & ~clr_err);
            udf     <= (rd & empty) | (udf & ~clr_err);
        end
    end
endmodule

// File: tb/tb_usb_sync_fifo.sv
// tb_usb_sync_fifo: directed self-checking bench for usb_sync_fifo
module tb_usb_sync_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr = 1'b0, rd = 1'b0, clr_err = 1'b0;
    logic [7:0] wdata = '0;
    logic [7:0] rdata;
    logic       full, fullm1, empty, emptyp1, ovf, udf;
    logic [4:0] level;
    int tests = 0;
    int fails = 0;

    usb_sync_fifo #(.DW(8), .AW(4)) dut (
        .clk(clk), .rst(rst), .wr(wr), .wdata(wdata), .rd(rd), .rdata(rdata),
        .full(full), .fullm1(fullm1), .empty(empty), .emptyp1(emptyp1),
        .level(level), .ovf(ovf), .udf(udf), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_errors();
        wr = 0; rd = 0; clr_err = 1;
        step();
        clr_err = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        step();
        tests++; if (empty !== 1'b1) begin fails++; $display("FAIL reset_empty got %b exp 1", empty); end
        tests++; if (emptyp1 !== 1'b1) begin fails++; $display("FAIL reset_emptyp1 got %b exp 1", emptyp1); end
        tests++; if (full !== 1'b0) begin fails++; $display("FAIL reset_full got %b exp 0", full); end
        tests++; if (fullm1 !== 1'b0) begin fails++; $display("FAIL reset_fullm1 got %b exp 0", fullm1); end
        tests++; if (level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d exp 0", level); end
        tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h exp 00", rdata); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b exp 0", ovf); end
        tests++; if (udf !== 1'b0) begin fails++; $display("FAIL reset_udf got %b exp 0", udf); end
        #3 rst = 0;
    endtask

    task automatic test_fill_drain();
        wr = 1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'(i);
            step();
            if (i == 13) begin
                tests++; if (fullm1 !== 1'b0) begin fails++; $display("FAIL fill_fullm1_14 got %b exp 0", fullm1); end
            end
            if (i == 14) begin
                tests++; if (fullm1 !== 1'b1 || full !== 1'b0) begin fails++; $display("FAIL fill_15 got fullm1=%b full=%b exp 1 0", fullm1, full); end
            end
        end
        tests++; if (full !== 1'b1 || level !== 5'd16) begin fails++; $display("FAIL fill_16 got full=%b level=%0d exp 1 16", full, level); end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL fill_no_ovf got %b exp 0", ovf); end
        wdata = 8'hEE;
        step();
        tests++; if (ovf !== 1'b1 || level !== 5'd16) begin fails++; $display("FAIL overflow got ovf=%b level=%0d exp 1 16", ovf, level); end
        wr = 0; rd = 1;
        for (int i = 0; i < 16; i++) begin
            step();
            tests++; if (rdata !== 8'(i)) begin fails++; $display("FAIL drain_data[%0d] got %h exp %h", i, rdata, 8'(i)); end
        end
        rd = 0;
        tests++; if (empty !== 1'b1 || level !== 5'd0) begin fails++; $display("FAIL drain_empty got empty=%b level=%0d exp 1 0", empty, level); end
        clear_errors();
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL clr_ovf got %b exp 0", ovf); end
    endtask

    task automatic test_low_level();
        wr = 1;
        for (int i = 0; i < 3; i++) begin
            wdata = 8'h31 + 8'(i);
            step();
        end
        wr = 0;
        tests++; if (emptyp1 !== 1'b0 || level !== 5'd3) begin fails++; $display("FAIL three_level got emptyp1=%b level=%0d exp 0 3", emptyp1, level); end
        rd = 1;
        step();
        step();
        tests++; if (emptyp1 !== 1'b1 || empty !== 1'b0 || rdata !== 8'h32) begin fails++; $display("FAIL one_left got emptyp1=%b empty=%b rdata=%h exp 1 0 32", emptyp1, empty, rdata); end
        step();
        tests++; if (empty !== 1'b1 || rdata !== 8'h33 || udf !== 1'b0) begin fails++; $display("FAIL now_empty got empty=%b rdata=%h udf=%b exp 1 33 0", empty, rdata, udf); end
        step();
        rd = 0;
        tests++; if (udf !== 1'b1 || rdata !== 8'h33 || level !== 5'd0) begin fails++; $display("FAIL underflow got udf=%b rdata=%h level=%0d exp 1 33 0", udf, rdata, level); end
        clear_errors();
        tests++; if (udf !== 1'b0) begin fails++; $display("FAIL clr_udf got %b exp 0", udf); end
    endtask

    task automatic test_full_rw();
        wr = 1;
        for (int i = 0; i < 16; i++) begin
            wdata = 8'(8'h40 + i);
            step();
        end
        rd = 1;
        for (int i = 0; i < 20; i++) begin
            wdata = 8'(8'h50 + i);
            step();
            tests++; if (rdata !== 8'(8'h40 + i) || level !== 5'd16 || full !== 1'b1) begin fails++; $display("FAIL full_rw[%0d] got rdata=%h level=%0d full=%b exp %h 16 1", i, rdata, level, full, 8'(8'h40 + i)); end
        end
        tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL full_rw_ovf got %b exp 0", ovf); end
        wr = 0;
        for (int i = 0; i < 16; i++) begin
            step();
            tests++; if (rdata !== 8'(8'h54 + i)) begin fails++; $display("FAIL full_rw_drain[%0d] got %h exp %h", i, rdata, 8'(8'h54 + i)); end
        end
        rd = 0;
        step();
        tests++; if (empty !== 1'b1 || udf !== 1'b0) begin fails++; $display("FAIL full_rw_end got empty=%b udf=%b exp 1 0", empty, udf); end
    endtask

    task automatic test_empty_rw();
        wr = 1; rd = 1; wdata = 8'hA5;
        step();
        wr = 0; rd = 0;
        tests++; if (level !== 5'd1 || udf !== 1'b1 || rdata !== 8'h63) begin fails++; $display("FAIL empty_rw got level=%0d udf=%b rdata=%h exp 1 1 63", level, udf, rdata); end
        rd = 1;
        step();
        rd = 0;
        tests++; if (rdata !== 8'hA5 || empty !== 1'b1) begin fails++; $display("FAIL empty_rw_read got rdata=%h empty=%b exp a5 1", rdata, empty); end
        clear_errors();
    endtask

    task automatic test_reset_mid();
        wr = 1;
        for (int i = 0; i < 5; i++) begin
            wdata = 8'h70 + 8'(i);
            step();
        end
        rd = 1;
        step();
        wr = 0; rd = 1; wdata = 8'hEE;
        #2 rst = 1;
        #1;
        tests++; if (level !== 5'd0 || empty !== 1'b1 || emptyp1 !== 1'b1 || fullm1 !== 1'b0 || rdata !== 8'h00) begin fails++; $display("FAIL async_reset got level=%0d empty=%b emptyp1=%b fullm1=%b rdata=%h exp 0 1 1 0 00", level, empty, emptyp1, fullm1, rdata); end
        rd = 0;
        #1 rst = 0;
        wr = 1; wdata = 8'h77;
        step();
        wr = 0;
        tests++; if (level !== 5'd1) begin fails++; $display("FAIL post_reset_level got %0d exp 1", level); end
        rd = 1;
        step();
        rd = 0;
        tests++; if (rdata !== 8'h77 || empty !== 1'b1 || udf !== 1'b0) begin fails++; $display("FAIL post_reset_read got rdata=%h empty=%b udf=%b exp 77 1 0", rdata, empty, udf); end
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_low_level();
        test_full_rw();
        test_empty_rw();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
